// File: rtl/branch_redirect_ctrl_pkg.sv
// branch_redirect_ctrl_pkg: opcodes, FSM state encodings and helpers shared by the
// redirect controller and the future hazard unit.
`default_nettype none

package branch_redirect_ctrl_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SQUASH   = 2'd2
    } state_e;

    function automatic logic is_jump(input logic [6:0] opc);
        return (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_redirect_ctrl_if.sv
// branch_redirect_ctrl_if: EX-side inputs and fetch/flush outputs of the redirect
// controller; master = pipeline side, slave = controller.
`default_nettype none

interface branch_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic [6:0]      ex_opcode;
    logic            ex_branch;
    logic [XLEN-1:0] ex_target;
    logic            stall;
    logic            fetch_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_if;
    logic            flush_id;
    logic            ex_squash;

    modport master (
        output ex_valid, ex_opcode, ex_branch, ex_target, stall, fetch_ready,
        input  redirect_valid, redirect_pc, flush_if, flush_id, ex_squash
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_branch, ex_target, stall, fetch_ready,
        output redirect_valid, redirect_pc, flush_if, flush_id, ex_squash
    );
endinterface

`default_nettype wire

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones; cleared by rst or clear.
`default_nettype none

module sat_counter #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc_i,
    input  wire logic         clear_i,
    output logic [W-1:0]      count_o
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
endmodule

`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: EX-resolved redirect sequencing (flush, held redirect, squash window).
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
`default_nettype none

module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int FETCH_LAT = 2,
    parameter int CNT_W     = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    branch_redirect_ctrl_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]      stat_branches,
    output logic [CNT_W-1:0]      stat_taken,
    output logic [CNT_W-1:0]      stat_jumps
`endif
);
    localparam logic [3:0] LAT_M1 = (FETCH_LAT == 0) ? 4'd0 : 4'(FETCH_LAT - 1);

    state_e          state_q, state_d;
    logic [3:0]      sq_cnt_q, sq_cnt_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            w_take;
    logic            w_rv, w_fi, w_fd, w_sq;

    // Branches seen while stalled are deferred until EX actually advances.
    assign w_take = (state_q == ST_IDLE) & ~rst & bus.ex_valid & ~bus.stall & bus.ex_branch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sq_cnt_q      <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            sq_cnt_q      <= sq_cnt_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sq_cnt_d      = sq_cnt_q;
        redirect_pc_d = redirect_pc_q;
        w_rv          = 1'b0;
        w_fi          = 1'b0;
        w_fd          = 1'b0;
        w_sq          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_take) begin
                    w_fi          = 1'b1;
                    w_fd          = 1'b1;
                    redirect_pc_d = {bus.ex_target[XLEN-1:1], 1'b0};
                    state_d       = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                w_rv = 1'b1;
                w_fi = 1'b1;
                w_sq = 1'b1;
                if (bus.fetch_ready) begin
                    if (FETCH_LAT == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        sq_cnt_d = LAT_M1;
                        state_d  = ST_SQUASH;
                    end
                end
            end
            ST_SQUASH: begin
                w_fi = 1'b1;
                w_sq = 1'b1;
                if (sq_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    sq_cnt_d = sq_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Reset silences everything in the cycle it is applied, whatever the state.
        if (rst) begin
            w_rv = 1'b0;
            w_fi = 1'b0;
            w_fd = 1'b0;
            w_sq = 1'b0;
        end
    end

    assign bus.redirect_valid = w_rv;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush_if       = w_fi;
    assign bus.flush_id       = w_fd;
    assign bus.ex_squash      = w_sq;

`ifdef BRANCH_STATS_EN
    logic w_evt, w_is_br;

    assign w_evt   = bus.ex_valid & ~bus.stall & (state_q == ST_IDLE);
    assign w_is_br = w_evt & (bus.ex_opcode == OPC_BRANCH);

    sat_counter #(.W(CNT_W)) u_cnt_branches (
        .clk(clk), .rst(rst), .inc_i(w_is_br), .clear_i(1'b0), .count_o(stat_branches)
    );
    sat_counter #(.W(CNT_W)) u_cnt_taken (
        .clk(clk), .rst(rst), .inc_i(w_is_br & bus.ex_branch), .clear_i(1'b0), .count_o(stat_taken)
    );
    sat_counter #(.W(CNT_W)) u_cnt_jumps (
        .clk(clk), .rst(rst), .inc_i(w_evt & is_jump(bus.ex_opcode)), .clear_i(1'b0),
        .count_o(stat_jumps)
    );
`endif
endmodule

`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed per-cycle vectors with a scoreboard queue checked
// by an independent negedge monitor.
`default_nettype none

module tb_branch_redirect_ctrl;
    import branch_redirect_ctrl_pkg::*;

    localparam int XLEN      = 32;
    localparam int FETCH_LAT = 2;
    localparam int CNT_W     = 2;

    logic clk;
    logic rst;

    branch_redirect_ctrl_if #(.XLEN(XLEN)) bus ();

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] stat_branches, stat_taken, stat_jumps;
`endif

    branch_redirect_ctrl #(
        .XLEN(XLEN), .FETCH_LAT(FETCH_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_taken(stat_taken),
        .stat_jumps(stat_jumps)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        fi;
        logic        fd;
        logic        sq;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (bus.redirect_valid !== mon_e.rv || bus.flush_if !== mon_e.fi ||
                bus.flush_id !== mon_e.fd || bus.ex_squash !== mon_e.sq ||
                (mon_e.rv && bus.redirect_pc !== mon_e.pc)) begin
                errors++;
                $display("FAIL %s: got rv=%b pc=%h fi=%b fd=%b sq=%b, expected rv=%b pc=%h fi=%b fd=%b sq=%b",
                         mon_e.name, bus.redirect_valid, bus.redirect_pc, bus.flush_if,
                         bus.flush_id, bus.ex_squash, mon_e.rv, mon_e.pc, mon_e.fi, mon_e.fd, mon_e.sq);
            end
        end
    end

    // One cycle of stimulus plus the outputs expected during that cycle.
    task automatic cyc(input logic v, input logic [6:0] opc, input logic br,
                       input logic [31:0] tgt, input logic st, input logic fr, input logic r,
                       input logic erv, input logic [31:0] epc, input logic efi,
                       input logic efd, input logic esq, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus.ex_valid    = v;
        bus.ex_opcode   = opc;
        bus.ex_branch   = br;
        bus.ex_target   = tgt;
        bus.stall       = st;
        bus.fetch_ready = fr;
        e.rv = erv; e.pc = epc; e.fi = efi; e.fd = efd; e.sq = esq; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string nm);
        cyc(0, 7'd0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 0, 0, nm);
    endtask

    // Take, one-cycle accepted redirect, then FETCH_LAT (2) squash cycles.
    task automatic take_seq(input logic [6:0] opc, input logic [31:0] tgt,
                            input logic [31:0] epc, input string nm);
        cyc(1, opc, 1, tgt, 0, 1, 0, 0, 32'h0, 1, 1, 0, {nm, "_take"});
        cyc(0, 7'd0, 0, 32'h0, 0, 1, 0, 1, epc, 1, 0, 1, {nm, "_redir"});
        cyc(0, 7'd0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 0, 1, {nm, "_sq0"});
        cyc(0, 7'd0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 0, 1, {nm, "_sq1"});
    endtask

    initial begin
        rst = 1'b1;
        bus.ex_valid = 0; bus.ex_opcode = 0; bus.ex_branch = 0;
        bus.ex_target = 0; bus.stall = 0; bus.fetch_ready = 0;

        cyc(0, 7'd0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 0, 0, "reset0");
        cyc(1, OPC_BRANCH, 1, 32'h104, 0, 1, 1, 0, 32'h0, 0, 0, 0, "reset_take_blocked");
        idle("reset_idle");

        // 1. BEQ taken, immediate accept
        take_seq(OPC_BRANCH, 32'h0000_0104, 32'h104, "beq");
        idle("beq_back_idle");

        // 2. fetch not ready for 3 cycles; target changes meanwhile must not leak
        cyc(1, OPC_BRANCH, 1, 32'h104, 0, 0, 0, 0, 32'h0, 1, 1, 0, "hold_take");
        cyc(1, OPC_BRANCH, 1, 32'h500, 0, 0, 0, 1, 32'h104, 1, 0, 1, "hold_w0");
        cyc(0, 7'd0, 0, 32'h600, 0, 0, 0, 1, 32'h104, 1, 0, 1, "hold_w1");
        cyc(0, 7'd0, 0, 32'h0, 0, 0, 0, 1, 32'h104, 1, 0, 1, "hold_w2");
        cyc(0, 7'd0, 0, 32'h0, 0, 1, 0, 1, 32'h104, 1, 0, 1, "hold_accept");
        cyc(0, 7'd0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 0, 1, "hold_sq0");
        cyc(0, 7'd0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 0, 1, "hold_sq1");
        idle("hold_idle");

        // 3. JALR with odd target: bit0 cleared
        take_seq(OPC_JALR, 32'h0000_0203, 32'h202, "jalr");

        // 4. BNE not taken
        cyc(1, OPC_BRANCH, 0, 32'h700, 0, 1, 0, 0, 32'h0, 0, 0, 0, "bne_nt");
        idle("bne_nt_after");

        // 5. stalled taken branch, then wrong-path branches during redirect/squash
        cyc(1, OPC_BRANCH, 1, 32'h0000_0810, 1, 1, 0, 0, 32'h0, 0, 0, 0, "stall0");
        cyc(1, OPC_BRANCH, 1, 32'h0000_0810, 1, 1, 0, 0, 32'h0, 0, 0, 0, "stall1");
        cyc(1, OPC_BRANCH, 1, 32'h0000_0810, 0, 1, 0, 0, 32'h0, 1, 1, 0, "stall_take");
        cyc(1, OPC_BRANCH, 1, 32'h0000_0900, 0, 1, 0, 1, 32'h810, 1, 0, 1, "stall_redir");
        cyc(1, OPC_BRANCH, 1, 32'h0000_0900, 0, 1, 0, 0, 32'h0, 1, 0, 1, "sq_ignore0");
        cyc(1, OPC_JAL, 1, 32'h0000_0900, 0, 1, 0, 0, 32'h0, 1, 0, 1, "sq_ignore1");
        idle("stall_idle");

        // 6. reset while in REDIRECT
        cyc(1, OPC_JAL, 1, 32'h0000_0300, 0, 0, 0, 0, 32'h0, 1, 1, 0, "rst_take");
        cyc(0, 7'd0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 0, 0, "rst_in_redir");
        cyc(0, 7'd0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, "rst_after");
        take_seq(OPC_BRANCH, 32'h0000_0400, 32'h400, "post_rst");

`ifdef BRANCH_STATS_EN
        cyc(0, 7'd0, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 0, 0, "stat_rst");
        take_seq(OPC_BRANCH, 32'h1000, 32'h1000, "stat_beq0");
        take_seq(OPC_BRANCH, 32'h1100, 32'h1100, "stat_beq1");
        cyc(1, OPC_BRANCH, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 0, 0, "stat_beq_nt");
        take_seq(OPC_JAL, 32'h1200, 32'h1200, "stat_jal");
        idle("stat_idle");
        @(negedge clk);
        #1;
        checks++;
        if (stat_branches !== 2'd3 || stat_taken !== 2'd2 || stat_jumps !== 2'd1) begin
            errors++;
            $display("FAIL stats: got br=%0d tk=%0d jmp=%0d, expected br=3 tk=2 jmp=1",
                     stat_branches, stat_taken, stat_jumps);
        end
        cyc(1, OPC_BRANCH, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 0, 0, "stat_sat0");
        cyc(1, OPC_BRANCH, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 0, 0, "stat_sat1");
        idle("stat_sat_idle");
        @(negedge clk);
        #1;
        checks++;
        if (stat_branches !== 2'd3) begin
            errors++;
            $display("FAIL stats_saturate: got br=%0d, expected br=3", stat_branches);
        end
`endif

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
